elbeth_pipeline_ctrl: RTL and testbench
=======================================

# elbeth_pipeline_ctrl

Central hazard and sequencing controller for the ELBETH 5-stage pipeline (IF, ID, EXS, MEM, WB). It generates the per-register stall and flush strobes consumed by the IF/ID, ID/EXS, EXS/MEM and MEM/WB pipeline registers, plus the PC stall and PC source select. It detects load-use hazards, instruction- and data-memory wait states, taken branches and MEM-stage traps/eret. A small FSM sequences multi-cycle data-memory waits and trap redirects.

## Interface
- REDIRECT_CYCLES, 2: cycles all younger stages stay flushed after a trap or eret (1..15).
- TIMEOUT_CYCLES, 256: consecutive data-memory wait cycles before a bus error (2..65535). Used only with the timeout feature.

Ports:
- clk  in  1  clock. One clock; all state changes on rising edge.
- rst  in  1  reset. Synchronous, active-high.
- id_rs1_addr, id_rs2_addr  in  5  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1  the ID instruction reads rs1 or rs2.
- exs_rd_addr  in  5  destination register of the instruction in EXS.
- exs_ctrl_reg_w, exs_ctrl_mem_en, exs_ctrl_mem_rw  in  1 each  EXS controls (mem_rw=1 is a store).
- exs_branch_taken  in  1  branch or jump resolved taken in EXS.
- mem_ctrl_mem_en  in  1  MEM stage holds an active data access.
- mem_exception, mem_eret  in  1  trap or eret committing in MEM.
- imem_ready, dmem_ready  in  1  memory ready handshakes.
- pc_stall  out  1  hold the PC.
- ifid_stall, idexs_stall, exsmem_stall, memwb_stall  out  1  hold the register.
- ifid_flush, idexs_flush, exsmem_flush, memwb_flush  out  1  load a bubble (zeros).
- pc_sel  out  2  PC source: 00 sequential, 01 branch target, 10 trap vector, 11 epc.
- bus_error  out  1  one-cycle data-bus timeout pulse.

## Operation
- FSM states: RUN, DWAIT, REDIRECT. There is a 4-bit redirect counter and a 16-bit wait counter.
- Events are evaluated in priority order: trap > dmem wait > branch > load-use > imem wait. Only the highest event acts. Flush wins over stall on the same register.
- Trap or eret: mem_exception or mem_eret in RUN or DWAIT.
  - pc_sel becomes 10 or 11 for that cycle (exception wins if both are set).
  - ifid, idexs and exsmem are flushed.
  - The FSM loads the counter with REDIRECT_CYCLES-1 and enters REDIRECT.
  - dmem_ready is ignored in that cycle.
- REDIRECT: ifid, idexs and exsmem flush every cycle and pc_sel=00. The counter decrements and the FSM returns to RUN after the cycle at count 0.
- Dmem wait: mem_ctrl_mem_en and !dmem_ready.
  - The PC and all four stall outputs are asserted, and memwb is flushed.
  - RUN goes to DWAIT, and the FSM stays in DWAIT until dmem_ready.
- Branch: pc_sel=01, ifid and idexs flushed, pc not stalled.
- Load-use: exs_ctrl_mem_en, !exs_ctrl_mem_rw, exs_ctrl_reg_w, exs_rd_addr!=0, and the rd matches a used rs1/rs2.
  - PC and ifid stalled, idexs flushed, for one cycle per occurrence.
- Imem wait: !imem_ready. PC stalled, ifid flushed.
- In REDIRECT only rst overrides. A new trap input is ignored until the FSM is back in RUN.

## Timing
- All strobes are combinational from the current inputs and state, with zero latency. They act on the pipeline registers at the same clock edge.
- Reset value, and value while rst=1:
  - state RUN, counters 0
  - all four flush outputs 1
  - all stalls 0
  - pc_sel 00
  - bus_error 0
- rst asserted mid-DWAIT or mid-REDIRECT aborts the sequence and leaves the FSM in RUN on the next cycle.
- A branch coincident with a dmem wait is held off. The EXS stage is stalled, so the branch is serviced on the first cycle dmem_ready=1.
- A load-use hazard coincident with a branch is not serviced. The flush removes the dependent instruction.

## Configuration
- ELBETH_PIPE_BUS_TIMEOUT_EN defined:
  - The wait counter increments each DWAIT cycle and clears on leaving DWAIT.
  - When it reaches TIMEOUT_CYCLES-1 with dmem_ready still 0, bus_error pulses for one cycle.
  - In that same cycle the controller behaves as a trap: pc_sel=10, ifid/idexs/exsmem flushed, memwb flushed, no stalls, and the FSM enters REDIRECT.
- Undefined: there is no wait counter, bus_error is tied to 0, and DWAIT persists indefinitely.

## Test plan
- Load-use: lw x5 in EXS, add using x5 in ID.
  - Expected: pc_stall=ifid_stall=idexs_flush=1 for exactly 1 cycle. With rd=x0 there is no stall.
- Dmem wait: dmem_ready low for 3 cycles.
  - Expected: all stalls=1 and memwb_flush=1 for 3 cycles, then RUN on ready.
- Branch during dmem wait, ready after 2 cycles.
  - Expected: pc_sel=01 only on the cycle after the wait ends, with ifid/idexs flushed.
- mem_exception, REDIRECT_CYCLES=2.
  - Expected: pc_sel=10 for 1 cycle, then 3 total cycles of ifid/idexs/exsmem flush, then RUN.
  - Repeat with mem_eret: pc_sel=11.
- rst pulse during REDIRECT.
  - Expected: all flushes=1 during rst, and the FSM is in RUN with stalls=0 on the cycle after rst.
- Timeout enabled, TIMEOUT_CYCLES=4, dmem_ready held 0.
  - Expected: bus_error pulses on the 4th wait cycle with pc_sel=10.
  - Same stimulus without the macro: bus_error stays 0.

Source files
------------

// File: rtl/elbeth_pipeline_ctrl_if.sv
// Handshake bundle between the ELBETH pipeline datapath and its hazard controller.
// The controller connects through the master modport; the datapath connects through
// the slave modport.
interface elbeth_pipeline_ctrl_if;
    // Hazard sources observed by the controller
    logic [4:0] id_rs1_addr;
    logic [4:0] id_rs2_addr;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic [4:0] exs_rd_addr;
    logic       exs_ctrl_reg_w;
    logic       exs_ctrl_mem_en;
    logic       exs_ctrl_mem_rw;
    logic       exs_branch_taken;
    logic       mem_ctrl_mem_en;
    logic       mem_exception;
    logic       mem_eret;
    logic       imem_ready;
    logic       dmem_ready;

    // Strobes produced by the controller
    logic       pc_stall;
    logic       ifid_stall;
    logic       idexs_stall;
    logic       exsmem_stall;
    logic       memwb_stall;
    logic       ifid_flush;
    logic       idexs_flush;
    logic       exsmem_flush;
    logic       memwb_flush;
    logic [1:0] pc_sel;
    logic       bus_error;

    modport master (
        input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        input  exs_rd_addr, exs_ctrl_reg_w, exs_ctrl_mem_en, exs_ctrl_mem_rw,
        input  exs_branch_taken, mem_ctrl_mem_en, mem_exception, mem_eret,
        input  imem_ready, dmem_ready,
        output pc_stall, ifid_stall, idexs_stall, exsmem_stall, memwb_stall,
        output ifid_flush, idexs_flush, exsmem_flush, memwb_flush,
        output pc_sel, bus_error
    );

    modport slave (
        output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2,
        output exs_rd_addr, exs_ctrl_reg_w, exs_ctrl_mem_en, exs_ctrl_mem_rw,
        output exs_branch_taken, mem_ctrl_mem_en, mem_exception, mem_eret,
        output imem_ready, dmem_ready,
        input  pc_stall, ifid_stall, idexs_stall, exsmem_stall, memwb_stall,
        input  ifid_flush, idexs_flush, exsmem_flush, memwb_flush,
        input  pc_sel, bus_error
    );
endinterface

// File: rtl/elbeth_pipeline_ctrl.sv
// Hazard and sequencing controller for the ELBETH 5-stage pipeline.
// Produces per-register stall/flush strobes, PC stall and PC source select.
// Optional feature: define ELBETH_PIPE_BUS_TIMEOUT_EN to enable the data-bus
// wait timeout (bus_error pulse plus trap-style redirect).
module elbeth_pipeline_ctrl #(
    parameter int unsigned REDIRECT_CYCLES = 2,
    parameter int unsigned TIMEOUT_CYCLES  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    elbeth_pipeline_ctrl_if.master        ctrl_if
);

    localparam logic [1:0] PcSeq    = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcTrap   = 2'b10;
    localparam logic [1:0] PcEpc    = 2'b11;

    // Reject out-of-range configurations at elaboration time
    if (REDIRECT_CYCLES < 1 || REDIRECT_CYCLES > 15 ||
        TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("elbeth_pipeline_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {StRun, StDwait, StRedirect} state_e;

    state_e     state_q, state_d;
    logic [3:0] redir_cnt_q, redir_cnt_d;

    logic       pc_stall, ifid_stall, idexs_stall, exsmem_stall, memwb_stall;
    logic       ifid_flush, idexs_flush, exsmem_flush, memwb_flush;
    logic [1:0] pc_sel;
    logic       bus_error;

    logic trap, dwait, load_use, rs1_hit, rs2_hit, timeout;

    assign trap  = ctrl_if.mem_exception | ctrl_if.mem_eret;
    assign dwait = ctrl_if.mem_ctrl_mem_en & ~ctrl_if.dmem_ready;

    assign rs1_hit  = ctrl_if.id_uses_rs1 && (ctrl_if.id_rs1_addr == ctrl_if.exs_rd_addr);
    assign rs2_hit  = ctrl_if.id_uses_rs2 && (ctrl_if.id_rs2_addr == ctrl_if.exs_rd_addr);
    assign load_use = ctrl_if.exs_ctrl_mem_en && !ctrl_if.exs_ctrl_mem_rw &&
                      ctrl_if.exs_ctrl_reg_w && (ctrl_if.exs_rd_addr != 5'd0) &&
                      (rs1_hit || rs2_hit);

`ifdef ELBETH_PIPE_BUS_TIMEOUT_EN
    logic [15:0] wait_cnt_q, wait_cnt_d;

    // Counts consecutive wait cycles; the first wait cycle (still in RUN) is count 0
    assign timeout = dwait && (wait_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // State and counter registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StRun;
            redir_cnt_q <= 4'd0;
`ifdef ELBETH_PIPE_BUS_TIMEOUT_EN
            wait_cnt_q  <= 16'd0;
`endif
        end else begin
            state_q     <= state_d;
            redir_cnt_q <= redir_cnt_d;
`ifdef ELBETH_PIPE_BUS_TIMEOUT_EN
            wait_cnt_q  <= wait_cnt_d;
`endif
        end
    end

    // Next-state and strobe decode; only the highest-priority event acts
    always_comb begin
        state_d      = state_q;
        redir_cnt_d  = redir_cnt_q;
`ifdef ELBETH_PIPE_BUS_TIMEOUT_EN
        wait_cnt_d   = 16'd0;
`endif
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        idexs_stall  = 1'b0;
        exsmem_stall = 1'b0;
        memwb_stall  = 1'b0;
        ifid_flush   = 1'b0;
        idexs_flush  = 1'b0;
        exsmem_flush = 1'b0;
        memwb_flush  = 1'b0;
        pc_sel       = PcSeq;
        bus_error    = 1'b0;

        if (rst) begin
            // Fill every pipeline register with bubbles while held in reset
            state_d      = StRun;
            redir_cnt_d  = 4'd0;
            ifid_flush   = 1'b1;
            idexs_flush  = 1'b1;
            exsmem_flush = 1'b1;
            memwb_flush  = 1'b1;
        end else if (state_q == StRedirect) begin
            ifid_flush   = 1'b1;
            idexs_flush  = 1'b1;
            exsmem_flush = 1'b1;
            if (redir_cnt_q == 4'd0) begin
                state_d = StRun;
            end else begin
                redir_cnt_d = redir_cnt_q - 4'd1;
            end
        end else if (trap) begin
            // dmem_ready is irrelevant here: the faulting access is being discarded
            pc_sel       = ctrl_if.mem_exception ? PcTrap : PcEpc;
            ifid_flush   = 1'b1;
            idexs_flush  = 1'b1;
            exsmem_flush = 1'b1;
            redir_cnt_d  = 4'(REDIRECT_CYCLES - 1);
            state_d      = StRedirect;
        end else if (timeout) begin
            // Bus timeout is handled as a trap that also kills the stuck access
            bus_error    = 1'b1;
            pc_sel       = PcTrap;
            ifid_flush   = 1'b1;
            idexs_flush  = 1'b1;
            exsmem_flush = 1'b1;
            memwb_flush  = 1'b1;
            redir_cnt_d  = 4'(REDIRECT_CYCLES - 1);
            state_d      = StRedirect;
        end else if (dwait) begin
            // Freeze everything upstream of WB; a pending branch waits in EXS
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idexs_stall  = 1'b1;
            exsmem_stall = 1'b1;
            memwb_stall  = 1'b1;
            memwb_flush  = 1'b1;
            state_d      = StDwait;
`ifdef ELBETH_PIPE_BUS_TIMEOUT_EN
            wait_cnt_d   = wait_cnt_q + 16'd1;
`endif
        end else begin
            state_d = StRun;
            if (ctrl_if.exs_branch_taken) begin
                // Branch flush also squashes any load-use dependent in ID
                pc_sel      = PcBranch;
                ifid_flush  = 1'b1;
                idexs_flush = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idexs_flush = 1'b1;
            end else if (!ctrl_if.imem_ready) begin
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
            end
        end
    end

    assign ctrl_if.pc_stall     = pc_stall;
    assign ctrl_if.ifid_stall   = ifid_stall;
    assign ctrl_if.idexs_stall  = idexs_stall;
    assign ctrl_if.exsmem_stall = exsmem_stall;
    assign ctrl_if.memwb_stall  = memwb_stall;
    assign ctrl_if.ifid_flush   = ifid_flush;
    assign ctrl_if.idexs_flush  = idexs_flush;
    assign ctrl_if.exsmem_flush = exsmem_flush;
    assign ctrl_if.memwb_flush  = memwb_flush;
    assign ctrl_if.pc_sel       = pc_sel;
    assign ctrl_if.bus_error    = bus_error;

endmodule

// File: tb/tb_elbeth_pipeline_ctrl.sv
// Directed bench for elbeth_pipeline_ctrl. Expected strobe vectors are queued when
// stimulus is applied and compared once the combinational outputs have settled.
// Honours ELBETH_PIPE_BUS_TIMEOUT_EN for the bus-timeout scenario.
module tb_elbeth_pipeline_ctrl;

    logic clk;
    logic rst;

    elbeth_pipeline_ctrl_if pif ();

    elbeth_pipeline_ctrl #(
        .REDIRECT_CYCLES (2),
        .TIMEOUT_CYCLES  (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_if (pif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {pc_stall, ifid/idexs/exsmem/memwb stall, ifid/idexs/exsmem/memwb flush, pc_sel, bus_error}
    logic [11:0] obs;
    assign obs = {pif.pc_stall, pif.ifid_stall, pif.idexs_stall, pif.exsmem_stall,
                  pif.memwb_stall, pif.ifid_flush, pif.idexs_flush, pif.exsmem_flush,
                  pif.memwb_flush, pif.pc_sel, pif.bus_error};

    localparam logic [11:0] E_RUN  = 12'b0_0000_0000_00_0;
    localparam logic [11:0] E_RST  = 12'b0_0000_1111_00_0;
    localparam logic [11:0] E_LU   = 12'b1_1000_0100_00_0;
    localparam logic [11:0] E_DW   = 12'b1_1111_0001_00_0;
    localparam logic [11:0] E_BR   = 12'b0_0000_1100_01_0;
    localparam logic [11:0] E_IM   = 12'b1_0000_1000_00_0;
    localparam logic [11:0] E_EXC  = 12'b0_0000_1110_10_0;
    localparam logic [11:0] E_ERET = 12'b0_0000_1110_11_0;
    localparam logic [11:0] E_RED  = 12'b0_0000_1110_00_0;
    localparam logic [11:0] E_TO   = 12'b0_0000_1111_10_1;

    logic [11:0] sb[$];
    int unsigned total  = 0;
    int unsigned passed = 0;

    // Benign inputs: no hazards, both memories ready
    task automatic idle();
        pif.id_rs1_addr      = 5'd1;
        pif.id_rs2_addr      = 5'd2;
        pif.id_uses_rs1      = 1'b0;
        pif.id_uses_rs2      = 1'b0;
        pif.exs_rd_addr      = 5'd0;
        pif.exs_ctrl_reg_w   = 1'b0;
        pif.exs_ctrl_mem_en  = 1'b0;
        pif.exs_ctrl_mem_rw  = 1'b0;
        pif.exs_branch_taken = 1'b0;
        pif.mem_ctrl_mem_en  = 1'b0;
        pif.mem_exception    = 1'b0;
        pif.mem_eret         = 1'b0;
        pif.imem_ready       = 1'b1;
        pif.dmem_ready       = 1'b1;
    endtask

    // Load in EXS writing rd
    task automatic load_in_exs(input logic [4:0] rd);
        pif.exs_ctrl_mem_en = 1'b1;
        pif.exs_ctrl_mem_rw = 1'b0;
        pif.exs_ctrl_reg_w  = 1'b1;
        pif.exs_rd_addr     = rd;
    endtask

    task automatic dmem_wait();
        pif.mem_ctrl_mem_en = 1'b1;
        pif.dmem_ready      = 1'b0;
    endtask

    // Queue the expectation for the inputs just driven, compare mid-cycle, advance
    task automatic step(input string tag, input logic [11:0] exp);
        logic [11:0] e;
        sb.push_back(exp);
        #2;
        e = sb.pop_front();
        total++;
        assert (obs === e) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %b expected %b", tag, obs, e);
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        rst = 1'b1;
        idle();
        step("reset0", E_RST);
        step("reset1", E_RST);
        rst = 1'b0;
        step("idle", E_RUN);

        // Load-use via rs1, then bubble behind it
        load_in_exs(5'd5); pif.id_rs1_addr = 5'd5; pif.id_uses_rs1 = 1'b1;
        step("lu_rs1", E_LU);
        idle();
        step("lu_done", E_RUN);
        load_in_exs(5'd7); pif.id_rs2_addr = 5'd7; pif.id_uses_rs2 = 1'b1;
        step("lu_rs2", E_LU);
        idle(); load_in_exs(5'd0); pif.id_rs1_addr = 5'd0; pif.id_uses_rs1 = 1'b1;
        step("lu_x0", E_RUN);
        idle(); load_in_exs(5'd5); pif.exs_ctrl_mem_rw = 1'b1;
        pif.id_rs1_addr = 5'd5; pif.id_uses_rs1 = 1'b1;
        step("lu_store", E_RUN);
        idle(); load_in_exs(5'd5); pif.id_rs1_addr = 5'd5;
        step("lu_unused", E_RUN);

        idle(); pif.imem_ready = 1'b0;
        step("imem_wait", E_IM);

        // Dmem wait for 3 cycles, then ready
        idle(); dmem_wait();
        step("dw1", E_DW);
        step("dw2", E_DW);
        step("dw3", E_DW);
        pif.dmem_ready = 1'b1;
        step("dw_ready", E_RUN);
        idle();
        step("dw_after", E_RUN);

        // Branch held off by a dmem wait
        dmem_wait(); pif.exs_branch_taken = 1'b1;
        step("brdw1", E_DW);
        step("brdw2", E_DW);
        pif.dmem_ready = 1'b1;
        step("brdw_br", E_BR);
        idle();
        step("brdw_after", E_RUN);

        // Branch beats load-use and imem wait
        load_in_exs(5'd9); pif.id_rs1_addr = 5'd9; pif.id_uses_rs1 = 1'b1;
        pif.exs_branch_taken = 1'b1; pif.imem_ready = 1'b0;
        step("br_lu", E_BR);

        // Exception with redirect; new trap/dwait ignored inside REDIRECT
        idle(); pif.mem_exception = 1'b1;
        step("exc", E_EXC);
        step("exc_red1", E_RED);
        idle(); dmem_wait(); pif.exs_branch_taken = 1'b1;
        step("exc_red2", E_RED);
        idle();
        step("exc_run", E_RUN);

        pif.mem_eret = 1'b1;
        step("eret", E_ERET);
        idle();
        step("eret_red1", E_RED);
        step("eret_red2", E_RED);
        step("eret_run", E_RUN);

        pif.mem_exception = 1'b1; pif.mem_eret = 1'b1;
        step("exc_eret", E_EXC);
        idle();
        step("ee_red1", E_RED);
        step("ee_red2", E_RED);
        step("ee_run", E_RUN);

        // Trap during dmem wait
        dmem_wait();
        step("tdw_dw", E_DW);
        pif.mem_exception = 1'b1;
        step("tdw_exc", E_EXC);
        idle();
        step("tdw_red1", E_RED);
        step("tdw_red2", E_RED);
        step("tdw_run", E_RUN);

        // Reset during REDIRECT, then a branch proves RUN
        pif.mem_exception = 1'b1;
        step("rr_exc", E_EXC);
        idle();
        step("rr_red", E_RED);
        rst = 1'b1;
        step("rr_rst", E_RST);
        rst = 1'b0; pif.exs_branch_taken = 1'b1;
        step("rr_br", E_BR);
        idle();

        // Reset during DWAIT
        dmem_wait();
        step("rd_dw", E_DW);
        rst = 1'b1;
        step("rd_rst", E_RST);
        rst = 1'b0; idle(); pif.exs_branch_taken = 1'b1;
        step("rd_br", E_BR);
        idle();
        step("rd_idle", E_RUN);

        // Data-bus wait held
        dmem_wait();
        step("to_w1", E_DW);
        step("to_w2", E_DW);
        step("to_w3", E_DW);
`ifdef ELBETH_PIPE_BUS_TIMEOUT_EN
        step("to_w4", E_TO);
        step("to_red1", E_RED);
        step("to_red2", E_RED);
        idle();
        step("to_run", E_RUN);
`else
        step("to_w4", E_DW);
        step("to_w5", E_DW);
        idle();
        step("to_run", E_RUN);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
